// File: rtl/axil_cfg_arbiter_if.sv
// AXI4-Lite bus bundle between the configuration arbiter and its register slave.
interface axil_cfg_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axil_cfg_arbiter.sv
// Round-robin arbiter serialising single-beat register commands onto one AXI4-Lite master.
module axil_cfg_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,
  axil_cfg_arbiter_if.master            m_axi
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  busy_q, busy_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand;
  logic [NUM_REQ-1:0]    gnt_onehot;

  // Round-robin search starting at rr_ptr; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant is a same-cycle accept pulse, so it is decoded combinationally from the search.
  assign req_ready  = (state_q == S_IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
  assign gnt_onehot = NUM_REQ'(1) << gnt_q;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d    = win_idx;
          addr_d   = req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d  = req_wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : PTR_W'(win_idx + PTR_W'(1));
          busy_d   = 1'b1;
          if (req_write[win_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W retire independently; move on once both have handshaken.
        if (m_axi.AWREADY) awvalid_d = 1'b0;
        if (m_axi.WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi.BVALID) begin
          bready_d    = 1'b0;
          resp_d      = m_axi.BRESP;
          rdata_d     = '0;
          rsp_valid_d = gnt_onehot;
          state_d     = S_DONE;
        end
      end
      S_RD_ADDR: begin
        if (m_axi.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axi.RVALID) begin
          rready_d    = 1'b0;
          rdata_d     = m_axi.RDATA;
          resp_d      = m_axi.RRESP;
          rsp_valid_d = gnt_onehot;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output registers; reset abandons any transaction in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign busy          = busy_q;
  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cfg_arbiter.sv
// Scoreboard bench for axil_cfg_arbiter with a small four-register AXI4-Lite slave model.
module tb_axil_cfg_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic [1:0]       rsp_resp;
  logic             busy;

  axil_cfg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_cfg_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .m_axi(bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int idx; logic [31:0] rdata; logic [1:0] resp; } rsp_t;
  rsp_t rsp_q[$];
  int   gnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_rsp(input int idx, input logic [31:0] d, input logic [1:0] r);
    rsp_t e;
    e.idx = idx; e.rdata = d; e.resp = r;
    rsp_q.push_back(e);
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  bit          b_hold = 1'b0;
  int          aw_cnt;
  logic        got_aw, got_w, b_pend, r_pend;
  logic [3:0]  aw_a;
  logic [31:0] w_d, r_data;
  logic [1:0]  b_resp;
  logic [31:0] regs [4];

  assign bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_delay);
  assign bus.WREADY  = bus.WVALID;
  assign bus.ARREADY = bus.ARVALID;
  assign bus.BVALID  = b_pend && !b_hold;
  assign bus.BRESP   = b_resp;
  assign bus.RVALID  = r_pend;
  assign bus.RDATA   = r_data;
  assign bus.RRESP   = 2'b00;

  wire        aw_hs = bus.AWVALID && bus.AWREADY;
  wire        w_hs  = bus.WVALID && bus.WREADY;
  wire        aw_ok = got_aw || aw_hs;
  wire        w_ok  = got_w || w_hs;
  wire [3:0]  wa    = got_aw ? aw_a : bus.AWADDR;
  wire [31:0] wd    = got_w ? w_d : bus.WDATA;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; w_d <= '0; r_data <= '0; b_resp <= 2'b00;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      aw_cnt <= (bus.AWVALID && !bus.AWREADY) ? aw_cnt + 1 : 0;
      if (bus.BVALID && bus.BREADY) b_pend <= 1'b0;
      if (aw_ok && w_ok && !b_pend) begin
        got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b1;
        if (wa == 4'h8) b_resp <= 2'b10;
        else begin b_resp <= 2'b00; regs[wa[3:2]] <= wd; end
      end else begin
        got_aw <= aw_ok; got_w <= w_ok; aw_a <= wa; w_d <= wd;
      end
      if (bus.ARVALID && bus.ARREADY) begin r_pend <= 1'b1; r_data <= regs[bus.ARADDR[3:2]]; end
      else if (bus.RVALID && bus.RREADY) r_pend <= 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int aw_hi = 0, w_hi = 0, b_hs = 0, rsp_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.AWVALID) aw_hi++;
      if (bus.WVALID) w_hi++;
      if (bus.BVALID && bus.BREADY) b_hs++;
      if (|req_ready) begin
        check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
        if (gnt_q.size() == 0) check("grant_unexpected", 32'(req_ready), 32'd0);
        else begin
          int g;
          g = gnt_q.pop_front();
          check("grant_idx", 32'(req_ready), 32'd1 << g);
        end
      end
      if (|rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int r, input bit wr, input logic [3:0] a, input logic [31:0] d,
                       output int tg);
    tg = -1;
    @(posedge clk); #1;
    req_write[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin tg = cyc; break; end
    end
    if (tg < 0) check("grant_timeout", 32'(req_ready[r]), 32'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(output int tr);
    tr = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (|rsp_valid) begin tr = cyc; break; end
    end
    if (tr < 0) check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || rsp_q.size() != 0 || gnt_q.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int t, tr, ng;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valids", {28'd0, bus.AWVALID, bus.WVALID, bus.ARVALID, 1'b0}, 32'd0);
    check("rst_readys", {30'd0, bus.BREADY, bus.RREADY}, 32'd0);
    check("rst_awaddr", 32'(bus.AWADDR), 32'd0);
    check("rst_wdata", bus.WDATA, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention: both requesting continuously, req0 writes 0xA5 to 0x0, req1 reads 0x0.
    @(posedge clk); #1;
    req_write = 2'b01;
    req_addr  = '0;
    req_wdata = {32'h0, 32'h000000A5};
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    exp_rsp(0, 32'h0, 2'b00); exp_rsp(1, 32'hA5, 2'b00);
    exp_rsp(0, 32'h0, 2'b00); exp_rsp(1, 32'hA5, 2'b00);
    req_valid = 2'b11;
    ng = 0;
    for (int k = 0; k < 100 && ng < 4; k++) begin
      @(negedge clk);
      if (|req_ready) ng++;
    end
    check("contention_grants", 32'(ng), 32'd4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Write 0x2 to 0x4 from req0 with cycle-accurate checks.
    gnt_q.push_back(0); exp_rsp(0, 32'h0, 2'b00);
    issue(0, 1'b1, 4'h4, 32'h2, t);
    @(negedge clk);
    check("wr_awaddr", 32'(bus.AWADDR), 32'h4);
    check("wr_wdata", bus.WDATA, 32'h2);
    check("wr_aw_w_valid", {30'd0, bus.AWVALID, bus.WVALID}, 32'd3);
    check("wr_busy", 32'(busy), 32'd1);
    wait_rsp(tr);
    check("wr_rsp_latency", 32'(tr - t), 32'd3);
    wait_idle();
    check("slave_reg1", regs[1], 32'h2);

    // Read back 0x4 from req1.
    gnt_q.push_back(1); exp_rsp(1, 32'h2, 2'b00);
    issue(1, 1'b0, 4'h4, 32'h0, t);
    wait_rsp(tr);
    check("rd_rsp_latency", 32'(tr - t), 32'd3);
    wait_idle();

    // Slave error on write to 0x8.
    gnt_q.push_back(0); exp_rsp(0, 32'h0, 2'b10);
    issue(0, 1'b1, 4'h8, 32'hDEAD_BEEF, t);
    wait_idle();

    // Split handshake: AWREADY delayed 3 cycles, WREADY immediate.
    aw_delay = 3;
    aw_hi = 0; w_hi = 0; b_hs = 0; rsp_cnt = 0;
    gnt_q.push_back(0); exp_rsp(0, 32'h0, 2'b00);
    issue(0, 1'b1, 4'h0, 32'h1234, t);
    wait_rsp(tr);
    check("split_rsp_latency", 32'(tr - t), 32'd6);
    wait_idle();
    check("split_awvalid_cycles", 32'(aw_hi), 32'd4);
    check("split_wvalid_cycles", 32'(w_hi), 32'd1);
    check("split_b_handshakes", 32'(b_hs), 32'd1);
    check("split_rsp_pulses", 32'(rsp_cnt), 32'd1);
    aw_delay = 0;

    // Reset while waiting in WR_RESP: transaction is abandoned with no response.
    b_hold = 1'b1;
    gnt_q.push_back(0);
    issue(0, 1'b1, 4'hC, 32'h77, t);
    tr = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.BREADY) begin tr = cyc; break; end
    end
    check("rst_reached_wr_resp", 32'(bus.BREADY), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_bready", 32'(bus.BREADY), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valids", {28'd0, bus.AWVALID, bus.WVALID, bus.ARVALID, bus.RREADY}, 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    b_hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // After reset only req1 requests; slave registers were cleared by the shared reset.
    gnt_q.push_back(1); exp_rsp(1, 32'h0, 2'b00);
    issue(1, 1'b0, 4'h4, 32'h0, t);
    wait_rsp(tr);
    check("post_rst_latency", 32'(tr - t), 32'd3);
    wait_idle();

    check("sb_rsp_drained", 32'(rsp_q.size()), 32'd0);
    check("sb_gnt_drained", 32'(gnt_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
